// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port DataMem arbiter.
//   arb_state_e : arbiter FSM states IDLE -> ISSUE -> WAIT -> RESP
//   PORT_CPU    : port index of the CPU load/store requester
//   PORT_DMA    : port index of the loader/DMA requester
//   ACK_LATENCY : cycles from Req sampled in IDLE to Ack high
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned ACK_LATENCY = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the DataMem.
//   Req/We/Addr/WData 0/1 : requester commands (requester -> arbiter)
//   Ack/RData 0/1         : completion pulse and read data (arbiter -> requester)
//   MemAddress/MemWriteData/MemRead/MemWrite : arbiter -> DataMem
//   MemReadData           : DataMem -> arbiter, registered, 1-cycle latency
//   Busy/GrantId          : arbiter status
// Modports: slave = arbiter side, master = requesters + DataMem side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              Req0;
  logic              We0;
  logic [ADDR_W-1:0] Addr0;
  logic [DATA_W-1:0] WData0;
  logic              Ack0;
  logic [DATA_W-1:0] RData0;

  logic              Req1;
  logic              We1;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] WData1;
  logic              Ack1;
  logic [DATA_W-1:0] RData1;

  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemReadData;

  logic              Busy;
  logic              GrantId;

  modport slave (
    input  Req0, We0, Addr0, WData0,
    input  Req1, We1, Addr1, WData1,
    input  MemReadData,
    output Ack0, RData0, Ack1, RData1,
    output MemAddress, MemWriteData, MemRead, MemWrite,
    output Busy, GrantId
  );

  modport master (
    output Req0, We0, Addr0, WData0,
    output Req1, We1, Addr1, WData1,
    output MemReadData,
    input  Ack0, RData0, Ack1, RData1,
    input  MemAddress, MemWriteData, MemRead, MemWrite,
    input  Busy, GrantId
  );

endinterface

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational winner select for the DataMem arbiter.
//   req0_i, req1_i  : pending requests
//   last_i          : port granted last (round-robin pointer)
//   gnt_valid_c_o   : at least one request pending
//   winner_c_o      : index of the winning port
// Build option ARB_ROUND_ROBIN_EN: alternate on contention; otherwise
// port 0 has fixed priority and last_i is ignored.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_valid_c_o,
  output logic winner_c_o
);

  assign gnt_valid_c_o = req0_i | req1_i;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the port not granted last wins; a lone requester always wins.
  always_comb begin
    winner_c_o = PORT_CPU;
    if (req0_i && req1_i) begin
      winner_c_o = ~last_i;
    end else if (req1_i) begin
      winner_c_o = PORT_DMA;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  // Port 0 wins whenever it requests.
  always_comb begin
    winner_c_o = PORT_CPU;
    if (req1_i && !req0_i) begin
      winner_c_o = PORT_DMA;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMem.
//   Clk, Rst : clock and synchronous active-high reset
//   bus      : dmem_arbiter_if.slave (requester ports, DataMem ports, status)
// One transaction per grant: IDLE latches the winner's command, ISSUE drives
// exactly one strobe, WAIT captures read data, RESP holds the Ack pulse.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration (see arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  dmem_arbiter_if.slave  bus
);

  arb_state_e        state_q,  state_d;
  logic              we_q,     we_d;
  logic              gnt_q,    gnt_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ack0_q,   ack0_d;
  logic              ack1_q,   ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q,   busy_d;

  logic              pick_valid;
  logic              pick_win;

  // GrantId doubles as the last-grant pointer.
  arb_pick u_pick (
    .req0_i        (bus.Req0),
    .req1_i        (bus.Req1),
    .last_i        (gnt_q),
    .gnt_valid_c_o (pick_valid),
    .winner_c_o    (pick_win)
  );

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic; strobes and Acks default low so each
  // is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_win;
          if (pick_win == PORT_DMA) begin
            we_d    = bus.We1;
            addr_d  = bus.Addr1;
            wdata_d = bus.WData1;
          end else begin
            we_d    = bus.We0;
            addr_d  = bus.Addr0;
            wdata_d = bus.WData0;
          end
          // Strobes are registered, so they are high during ISSUE.
          mem_wr_d = we_d;
          mem_rd_d = ~we_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // DataMem read data is valid this cycle; writes keep the old RData.
        if (gnt_q == PORT_DMA) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = bus.MemReadData;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = bus.MemReadData;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.MemAddress   = addr_q;
  assign bus.MemWriteData = wdata_q;
  assign bus.MemRead      = mem_rd_q;
  assign bus.MemWrite     = mem_wr_q;
  assign bus.Ack0         = ack0_q;
  assign bus.Ack1         = ack1_q;
  assign bus.RData0       = rdata0_q;
  assign bus.RData1       = rdata1_q;
  assign bus.Busy         = busy_q;
  assign bus.GrantId      = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural DataMem
// (registered read, 1-cycle latency, word index = address >> 2).
// Expected RData per port is queued when a command is driven and popped
// when the matching Ack appears. Honours ARB_ROUND_ROBIN_EN for grant order.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (ifc.slave)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h1234_5678;
    if (i >= 16 && i <= 23) return 32'hC0DE_0000 + 32'(i);
    return 32'h0;
  endfunction

  // Behavioural DataMem.
  logic [31:0] dmem [0:63];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
    end else begin
      if (ifc.MemWrite) dmem[ifc.MemAddress[7:2]] <= ifc.MemWriteData;
      if (ifc.MemRead)  ifc.MemReadData <= dmem[ifc.MemAddress[7:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  int strobe_cnt = 0;

  logic [31:0] ref_mem [0:63];
  logic [31:0] mdl_rd  [0:1];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        gq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Record the expected RData seen at this command's Ack.
  task automatic sb_push(input logic p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int w;
    w = int'(addr[7:2]);
    if (we) ref_mem[w] = wdata;
    else    mdl_rd[p]  = ref_mem[w];
    if (p) q1.push_back(mdl_rd[1]);
    else   q0.push_back(mdl_rd[0]);
    n_txn++;
  endtask

  task automatic set_cmd(input logic p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      ifc.Req1 = req; ifc.We1 = we; ifc.Addr1 = addr; ifc.WData1 = wdata;
    end else begin
      ifc.Req0 = req; ifc.We0 = we; ifc.Addr0 = addr; ifc.WData0 = wdata;
    end
  endtask

  // Protocol and scoreboard monitor.
  task automatic monitor();
    logic prev_strobe = 1'b0;
    logic strobe;
    forever begin
      @(negedge clk);
      strobe = ifc.MemRead | ifc.MemWrite;
      if (strobe) begin
        strobe_cnt++;
        chk("strobe_excl", 64'(ifc.MemRead & ifc.MemWrite), 64'(0));
        chk("strobe_1cyc", 64'(prev_strobe), 64'(0));
        chk("strobe_busy", 64'(ifc.Busy), 64'(1));
      end
      prev_strobe = strobe;
      if (ifc.Ack0 || ifc.Ack1) begin
        chk("ack_excl", 64'(ifc.Ack0 & ifc.Ack1), 64'(0));
        chk("ack_busy", 64'(ifc.Busy), 64'(1));
        if (ifc.Ack0) begin
          chk("sb0_pending", 64'(q0.size() != 0), 64'(1));
          if (q0.size() != 0) chk("rdata0", 64'(ifc.RData0), 64'(q0.pop_front()));
        end
        if (ifc.Ack1) begin
          chk("sb1_pending", 64'(q1.size() != 0), 64'(1));
          if (q1.size() != 0) chk("rdata1", 64'(ifc.RData1), 64'(q1.pop_front()));
        end
        if (gq.size() != 0) chk("grant_order", 64'(ifc.GrantId), 64'(gq.pop_front()));
      end
    end
  endtask

  // Single transaction from an idle arbiter; entered and left at a negedge.
  task automatic do_txn(input logic p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int k;
    logic seen;
    sb_push(p, we, addr, wdata);
    set_cmd(p, 1'b1, we, addr, wdata);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      chk("busy_active", 64'(ifc.Busy), 64'(1));
      if (k == 1) begin
        chk("grant_id", 64'(ifc.GrantId), 64'(p));
        chk("strobe_wr", 64'(ifc.MemWrite), 64'(we));
        chk("strobe_rd", 64'(ifc.MemRead), 64'(!we));
        chk("mem_addr", 64'(ifc.MemAddress), 64'(addr));
        if (we) chk("mem_wdata", 64'(ifc.MemWriteData), 64'(wdata));
        // Scramble the command after grant; the latched copy must be used.
        set_cmd(p, 1'b1, !we, ~addr, ~wdata);
      end
      if (k == 2) chk("addr_held", 64'(ifc.MemAddress), 64'(addr));
      seen = p ? ifc.Ack1 : ifc.Ack0;
    end
    chk("ack_latency", 64'(k), 64'(ACK_LATENCY));
    chk("other_ack", 64'(p ? ifc.Ack0 : ifc.Ack1), 64'(0));
    set_cmd(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ack_cleared", 64'(ifc.Ack0 | ifc.Ack1), 64'(0));
    chk("busy_idle", 64'(ifc.Busy), 64'(0));
  endtask

  // Back-to-back reads from one port, presenting the next command on each Ack.
  task automatic burst(input logic p, input int n, input int base_word);
    int cnt;
    logic [31:0] addr;
    for (int k = 0; k < n; k++) begin
      addr = 32'((base_word + k) * 4);
      sb_push(p, 1'b0, addr, 32'h0);
      set_cmd(p, 1'b1, 1'b0, addr, 32'h0);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(p ? ifc.Ack1 : ifc.Ack0) && cnt < 200);
      chk("burst_timeout", 64'(cnt >= 200), 64'(0));
    end
    set_cmd(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    rst = 1'b1;
    mem_load = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cmd(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_ack0",    64'(ifc.Ack0), 64'(0));
    chk("rst_ack1",    64'(ifc.Ack1), 64'(0));
    chk("rst_memrd",   64'(ifc.MemRead), 64'(0));
    chk("rst_memwr",   64'(ifc.MemWrite), 64'(0));
    chk("rst_grant",   64'(ifc.GrantId), 64'(0));
    chk("rst_rdata0",  64'(ifc.RData0), 64'(0));
    chk("rst_rdata1",  64'(ifc.RData1), 64'(0));
    chk("rst_addr",    64'(ifc.MemAddress), 64'(0));
    chk("rst_wdata",   64'(ifc.MemWriteData), 64'(0));
    chk("rst_busy",    64'(ifc.Busy), 64'(0));
    rst = 1'b0;
    mem_load = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);

    // Reset during WAIT of a port 0 read: no Ack, nothing captured.
    set_cmd(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    n_txn++;
    @(posedge clk); @(negedge clk);
    chk("wrst_issue_rd", 64'(ifc.MemRead), 64'(1));
    @(posedge clk); @(negedge clk);
    chk("wrst_busy_wait", 64'(ifc.Busy), 64'(1));
    rst = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("wrst_ack0",   64'(ifc.Ack0), 64'(0));
    chk("wrst_ack1",   64'(ifc.Ack1), 64'(0));
    chk("wrst_busy",   64'(ifc.Busy), 64'(0));
    chk("wrst_rdata0", 64'(ifc.RData0), 64'(0));
    repeat (3) @(negedge clk);
    chk("wrst_no_late_ack", 64'(ifc.Ack0 | ifc.Ack1), 64'(0));

    // Port 0 write then readback, port 1 read of a preloaded word.
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b0, 32'h10, 32'h0);
    chk("rdata0_readback", 64'(ifc.RData0), 64'(32'hDEAD_BEEF));
    do_txn(1'b1, 1'b0, 32'h8, 32'h0);
    chk("rdata1_preload", 64'(ifc.RData1), 64'(32'h1234_5678));
    do_txn(1'b1, 1'b1, 32'h14, 32'h5555_AAAA);
    chk("rdata1_kept_on_write", 64'(ifc.RData1), 64'(32'h1234_5678));

    // Contention: both ports request four reads each; last grant was port 1.
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) gq.push_back(1'(i % 2));
`else
    for (int i = 0; i < 8; i++) gq.push_back(i >= 4);
`endif
    fork
      burst(1'b0, 4, 16);
      burst(1'b1, 4, 20);
    join
    repeat (2) @(negedge clk);
    chk("burst_grants_done", 64'(gq.size()), 64'(0));
    chk("burst_busy", 64'(ifc.Busy), 64'(0));

    // Reset during ISSUE of a write: write lands, no Ack.
    set_cmd(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
    n_txn++;
    @(posedge clk); @(negedge clk);
    chk("irst_issue_wr", 64'(ifc.MemWrite), 64'(1));
    rst = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    ref_mem[8] = 32'hA5A5_A5A5;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    chk("irst_busy", 64'(ifc.Busy), 64'(0));
    chk("irst_memwr", 64'(ifc.MemWrite), 64'(0));
    repeat (3) @(negedge clk);
    chk("irst_no_ack", 64'(ifc.Ack0 | ifc.Ack1), 64'(0));
    do_txn(1'b0, 1'b0, 32'h20, 32'h0);
    chk("irst_readback", 64'(ifc.RData0), 64'(32'hA5A5_A5A5));

    repeat (2) @(negedge clk);
    chk("sb0_drained", 64'(q0.size()), 64'(0));
    chk("sb1_drained", 64'(q1.size()), 64'(0));
    chk("strobe_total", 64'(strobe_cnt), 64'(n_txn));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port DataMem between two requesters: port 0 is the CPU load/store path and port 1 is a loader/DMA path. Each requester issues a one-transaction request/acknowledge handshake. The arbiter picks a winner and latches its command. It drives the DataMem strobes for exactly one cycle, captures the registered read data and returns an acknowledge. It sits between the datapath and the DataMem instance, replacing the direct MemRead/MemWrite hookup.

Parameters:
ADDR_W, 32, width of request and memory addresses
DATA_W, 32, width of read/write data

Ports:
Clk  input  1  single clock, all state changes on posedge
Rst  input  1  synchronous active-high reset
Req0  input  1  port 0 request; held until Ack0
We0  input  1  port 0 write (1) / read (0)
Addr0  input  ADDR_W  port 0 byte address
WData0  input  DATA_W  port 0 write data
Ack0  output  1  one-cycle completion pulse, port 0
RData0  output  DATA_W  port 0 read data, valid while Ack0=1
Req1, We1, Addr1, WData1, Ack1, RData1  same as port 0, for port 1
MemAddress  output  ADDR_W  to DataMem Address
MemWriteData  output  DATA_W  to DataMem writeData
MemRead  output  1  to DataMem MemRead
MemWrite  output  1  to DataMem MemWrite
MemReadData  input  DATA_W  from DataMem ReadData, registered, 1-cycle latency
Busy  output  1  high in any state other than IDLE
GrantId  output  1  index of the current or last granted port

Behaviour:
- Clocking: one clock Clk. Reset Rst is synchronous and active-high.
- Reset: state=IDLE. Ack0, Ack1, MemRead, MemWrite and GrantId are 0. RData0, RData1, MemAddress and MemWriteData are 0. The round-robin pointer is 0.
- FSM has four states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any Req is high, select a winner. Latch its Addr, WData and We into MemAddress, MemWriteData and the write flag. Set GrantId. Go to ISSUE. If no Req is high, stay in IDLE.
- ISSUE (1 cycle): MemWrite=We and MemRead=~We, both registered. DataMem performs the operation at the closing edge.
- WAIT (1 cycle): strobes are 0. MemReadData is valid. At the closing edge, RDataX<=MemReadData (reads only; a write leaves RDataX unchanged) and AckX<=1 for X=GrantId.
- RESP (1 cycle): AckX=1. The requester must drop ReqX or present its next command. The arbiter ignores Req inputs in RESP. At the closing edge, Ack is cleared and the state returns to IDLE.
- Latency: Req sampled high in IDLE at cycle n gives Ack high in cycle n+3. Peak throughput is 1 transaction per 4 cycles.
- Exactly one of MemRead/MemWrite is high, and only in ISSUE. Both are never high together.
- Addresses pass through unchanged; DataMem performs the >>2 word conversion. Misaligned addresses are not checked.
- Selection without the optional feature is fixed priority: port 0 wins when Req0 and Req1 are both high.
- Changes to a requester's inputs after grant have no effect on the latched command.
- Rst during ISSUE: the DataMem still samples the pre-edge strobes, so an in-flight write completes. No Ack is issued, and the state returns to IDLE.
- Rst during WAIT or RESP: Ack is cleared at that edge; no partial Ack beyond it.
- Req deasserted before Ack is a protocol violation; the latched transaction still completes and acks.

Optional Feature:
ARB_ROUND_ROBIN_EN. When defined, on simultaneous requests the winner is the port that was not granted last: the pointer holds the last GrantId and updates on each grant. A single requester always wins regardless of the pointer. When not defined, fixed priority applies (port 0 wins), the pointer is not implemented, and port 1 can starve.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, RESP};
  - constants PORT_CPU=0 and PORT_DMA=1;
  - localparam ACK_LATENCY=3.
- One natural sub-module, arb_pick: combinational winner select. Inputs are Req0, Req1 and the last-grant pointer; outputs are the grant-valid signal and the winner index. It contains the ARB_ROUND_ROBIN_EN conditional.

Test Plan:
- Port 0 write: Req0=1, We0=1, Addr0=0x10, WData0=0xDEADBEEF -> MemWrite=1 for one cycle with MemAddress=0x10; Ack0 in cycle n+3. A following port 0 read of 0x10 -> RData0=0xDEADBEEF with Ack0.
- Port 1 read of preloaded word 0x8 (DMemory[2]=0x12345678) -> MemRead pulse, then Ack1=1 and RData1=0x12345678; Ack0 stays 0.
- Simultaneous Req0=Req1=1, 4 back-to-back transactions:
  - fixed priority -> GrantId=0,0,0,0 (port 1 starves);
  - with ARB_ROUND_ROBIN_EN -> GrantId=0,1,0,1.
- Rst asserted in ISSUE of a write to 0x20 (data 0xA5A5A5A5) -> no Ack, FSM in IDLE; a later read of 0x20 returns 0xA5A5A5A5.
- Rst asserted in WAIT of a read -> Ack0/Ack1 remain 0, Busy=0 next cycle, RData unchanged.
- Protocol check across all tests: MemRead&MemWrite never both 1, each strobe high exactly 1 cycle per transaction, and Busy=0 only in IDLE.
